// File: rtl/addr_demux12.sv
// ============================================================================
// Module   : addr_demux12
// Brief    : Routes addresses into one of two independent FIFO queues (A/B).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module addr_demux12_fifo #(
  parameter int AddrWidth = 24,
  parameter int Depth     = 2
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 push_i,
  input  logic [AddrWidth-1:0] data_i,
  input  logic                 pop_i,
  output logic                 full_o,
  output logic                 valid_o,
  output logic [AddrWidth-1:0] head_o,
  output logic [2:0]           count_o
);

  localparam int       PtrW    = $clog2(Depth);
  localparam bit [2:0] C_DEPTH = 3'(Depth);

  logic [AddrWidth-1:0] mem_q [Depth];
  logic [PtrW-1:0]      wr_ptr_q;
  logic [PtrW-1:0]      rd_ptr_q;
  logic [2:0]           count_q;
  logic [2:0]           count_d;
  logic                 w_push;
  logic                 w_pop;

  // Fullness is judged before any same-cycle pop, so a full queue never
  // accepts even while draining.
  assign full_o  = (count_q == C_DEPTH);
  assign valid_o = (count_q != 3'd0);
  assign head_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

  assign w_push = push_i && !full_o;
  assign w_pop  = pop_i && valid_o;

  always_comb begin
    count_d = count_q;
    case ({w_push, w_pop})
      2'b10:   count_d = count_q + 3'd1;
      2'b01:   count_d = count_q - 3'd1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < Depth; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      if (w_push) begin
        mem_q[wr_ptr_q] <= data_i;
        wr_ptr_q        <= wr_ptr_q + PtrW'(1);
      end
      if (w_pop) begin
        rd_ptr_q <= rd_ptr_q + PtrW'(1);
      end
      count_q <= count_d;
    end
  end

endmodule

module addr_demux12 #(
  parameter int AddrWidth = 24,
  parameter int Depth     = 2
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [AddrWidth-1:0] in_addr,
  input  logic                 in_sel,
  input  logic                 in_valid,
  output logic                 in_ready,
  output logic [AddrWidth-1:0] a_addr,
  output logic                 a_valid,
  input  logic                 a_ready,
  output logic [AddrWidth-1:0] b_addr,
  output logic                 b_valid,
  input  logic                 b_ready,
  output logic [2:0]           a_count,
  output logic [2:0]           b_count
);

  logic w_a_full;
  logic w_b_full;
  logic w_push_a;
  logic w_push_b;

  assign in_ready = in_sel ? !w_a_full : !w_b_full;
  assign w_push_a = in_valid && in_sel;
  assign w_push_b = in_valid && !in_sel;

  addr_demux12_fifo #(
    .AddrWidth (AddrWidth),
    .Depth     (Depth)
  ) u_queue_a (
    .clk     (clk),
    .reset_n (reset_n),
    .push_i  (w_push_a),
    .data_i  (in_addr),
    .pop_i   (a_ready),
    .full_o  (w_a_full),
    .valid_o (a_valid),
    .head_o  (a_addr),
    .count_o (a_count)
  );

  addr_demux12_fifo #(
    .AddrWidth (AddrWidth),
    .Depth     (Depth)
  ) u_queue_b (
    .clk     (clk),
    .reset_n (reset_n),
    .push_i  (w_push_b),
    .data_i  (in_addr),
    .pop_i   (b_ready),
    .full_o  (w_b_full),
    .valid_o (b_valid),
    .head_o  (b_addr),
    .count_o (b_count)
  );

endmodule

`default_nettype wire

// File: tb/tb_addr_demux12.sv
// ============================================================================
// Module   : tb_addr_demux12
// Brief    : Directed and random checks of addr_demux12 against a queue model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_addr_demux12;

  localparam int AW = 24;
  localparam int DEPTH = 2;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic [AW-1:0] in_addr = '0;
  logic          in_sel = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [AW-1:0] a_addr;
  logic          a_valid;
  logic          a_ready = 1'b0;
  logic [AW-1:0] b_addr;
  logic          b_valid;
  logic          b_ready = 1'b0;
  logic [2:0]    a_count;
  logic [2:0]    b_count;

  int n_pass = 0;
  int n_total = 0;

  logic [AW-1:0] qa [$];
  logic [AW-1:0] qb [$];

  always #5 clk = ~clk;

  addr_demux12 #(.AddrWidth(AW), .Depth(DEPTH)) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .in_addr  (in_addr),
    .in_sel   (in_sel),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .a_addr   (a_addr),
    .a_valid  (a_valid),
    .a_ready  (a_ready),
    .b_addr   (b_addr),
    .b_valid  (b_valid),
    .b_ready  (b_ready),
    .a_count  (a_count),
    .b_count  (b_count)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic chk_outputs();
    chk("a_count", 32'(a_count), 32'(qa.size()));
    chk("b_count", 32'(b_count), 32'(qb.size()));
    chk("a_valid", 32'(a_valid), 32'(qa.size() != 0));
    chk("b_valid", 32'(b_valid), 32'(qb.size() != 0));
    if (qa.size() != 0) chk("a_addr", 32'(a_addr), 32'(qa[0]));
    if (qb.size() != 0) chk("b_addr", 32'(b_addr), 32'(qb[0]));
  endtask

  // One clock: drive at negedge, check in_ready, update model on the edge,
  // then check the registered outputs.
  task automatic cyc(input logic rn, input logic v, input logic sel,
                     input logic [AW-1:0] addr, input logic ar, input logic br);
    bit exp_rdy;
    @(negedge clk);
    reset_n  = rn;
    in_valid = v;
    in_sel   = sel;
    in_addr  = addr;
    a_ready  = ar;
    b_ready  = br;
    #1;
    exp_rdy = sel ? (qa.size() < DEPTH) : (qb.size() < DEPTH);
    chk("in_ready", 32'(in_ready), 32'(exp_rdy));
    @(posedge clk);
    if (!rn) begin
      qa.delete();
      qb.delete();
    end else begin
      if (ar && qa.size() != 0) void'(qa.pop_front());
      if (br && qb.size() != 0) void'(qb.pop_front());
      if (v && exp_rdy) begin
        if (sel) qa.push_back(addr);
        else     qb.push_back(addr);
      end
    end
    #1;
    chk_outputs();
  endtask

  initial begin
    // Reset state
    cyc(1'b0, 1'b0, 1'b1, '0, 1'b0, 1'b0);
    chk("rst_a_addr", 32'(a_addr), 32'h0);
    chk("rst_b_addr", 32'(b_addr), 32'h0);
    chk("rst_in_ready", 32'(in_ready), 32'h1);

    // Single push to A
    cyc(1'b1, 1'b1, 1'b1, 24'h000ABC, 1'b0, 1'b0);
    chk("first_a_addr", 32'(a_addr), 32'h000ABC);
    chk("first_a_count", 32'(a_count), 32'h1);
    cyc(1'b0, 1'b0, 1'b1, '0, 1'b0, 1'b0);

    // Fill A, third refused, then drain
    cyc(1'b1, 1'b1, 1'b1, 24'h111111, 1'b0, 1'b0);
    cyc(1'b1, 1'b1, 1'b1, 24'h222222, 1'b0, 1'b0);
    cyc(1'b1, 1'b1, 1'b1, 24'h333333, 1'b0, 1'b0);
    chk("full_in_ready", 32'(in_ready), 32'h0);
    chk("full_a_count", 32'(a_count), 32'h2);

    // A full, B still accepts
    cyc(1'b1, 1'b1, 1'b0, 24'h0000B0, 1'b0, 1'b0);
    chk("b_addr_b0", 32'(b_addr), 32'h0000B0);
    chk("a_head_kept", 32'(a_addr), 32'h111111);

    // Full queue refuses even while popped in the same cycle
    cyc(1'b1, 1'b1, 1'b1, 24'h555555, 1'b1, 1'b0);
    chk("drain1_a_addr", 32'(a_addr), 32'h222222);
    cyc(1'b1, 1'b0, 1'b1, '0, 1'b1, 1'b0);
    chk("drain2_a_valid", 32'(a_valid), 32'h0);

    // Push + pop on one-entry queue
    cyc(1'b1, 1'b1, 1'b1, 24'h123456, 1'b0, 1'b0);
    cyc(1'b1, 1'b1, 1'b1, 24'h444444, 1'b1, 1'b0);
    chk("pp_a_count", 32'(a_count), 32'h1);
    chk("pp_a_addr", 32'(a_addr), 32'h444444);

    // Reset mid-operation with input offered
    cyc(1'b1, 1'b1, 1'b1, 24'hAAAAAA, 1'b0, 1'b0);
    cyc(1'b1, 1'b1, 1'b0, 24'hBBBBBB, 1'b0, 1'b0);
    cyc(1'b0, 1'b1, 1'b1, 24'hCCCCCC, 1'b1, 1'b1);
    chk("mid_rst_a_addr", 32'(a_addr), 32'h0);
    chk("mid_rst_b_addr", 32'(b_addr), 32'h0);
    chk("mid_rst_a_count", 32'(a_count), 32'h0);

    // Random traffic against the model
    for (int i = 0; i < 10000; i++) begin
      cyc(1'b1, 1'($urandom_range(0, 3) != 0), 1'($urandom), AW'($urandom),
          1'($urandom_range(0, 2) == 0), 1'($urandom_range(0, 2) == 0));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

`default_nettype wire
